// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with 16x oversampling; decodes ASCII drive characters into
// 3-bit commands on a valid/ready handshake with sticky error flags.
module uart_cmd_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       cmd_ready,
    input  logic       err_clear,
    output logic [7:0] rx_data,
    output logic       rx_byte_valid,
    output logic [2:0] command,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       unknown_err,
    output logic       overrun_err
);

    localparam int TICK_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_meta, rx_s;
    logic [1:0]    sync_init;
    logic          armed;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    os;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          stop_pt, good_stop, bad_stop;
    logic          dec_hit, dec_unk, new_cmd;
    logic [2:0]    dec_code;

    // sync_init marks when rx_s reflects the real line rather than the reset preset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_init <= 2'b00;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            sync_init <= {sync_init[0], 1'b1};
        end
    end

    assign tick = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (state == IDLE || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign stop_pt   = (state == STOP) && tick && (os == 4'd15);
    assign good_stop = stop_pt && rx_s;
    assign bad_stop  = stop_pt && !rx_s;

    always_comb begin
        dec_hit  = 1'b1;
        dec_unk  = 1'b0;
        dec_code = 3'd0;
        case (shift)
            8'h53: dec_code = 3'd0;
            8'h46: dec_code = 3'd1;
            8'h42: dec_code = 3'd2;
            8'h4C: dec_code = 3'd3;
            8'h52: dec_code = 3'd4;
            8'h43: dec_code = 3'd5;
            8'h54: dec_code = 3'd6;
            8'h58: dec_code = 3'd7;
            8'h0D, 8'h0A: dec_hit = 1'b0;
            default: begin
                dec_hit = 1'b0;
                dec_unk = 1'b1;
            end
        endcase
    end

    assign new_cmd = good_stop && dec_hit;

    // armed stays low after reset until the line is seen idle, discarding a cut-off frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            os      <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            armed   <= 1'b0;
        end else begin
            if (sync_init[1] && rx_s)
                armed <= 1'b1;
            case (state)
                IDLE: if (armed && !rx_s) begin
                    state <= START;
                    os    <= 4'd0;
                end
                START: if (tick) begin
                    if (os == 4'd7) begin
                        os      <= 4'd0;
                        bit_cnt <= 3'd0;
                        state   <= rx_s ? IDLE : DATA;
                    end else
                        os <= os + 4'd1;
                end
                DATA: if (tick) begin
                    if (os == 4'd15) begin
                        os    <= 4'd0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end else
                        os <= os + 4'd1;
                end
                STOP: if (tick) begin
                    if (os == 4'd15) begin
                        os    <= 4'd0;
                        state <= IDLE;
                    end else
                        os <= os + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data       <= 8'd0;
            rx_byte_valid <= 1'b0;
            command       <= 3'd0;
            cmd_valid     <= 1'b0;
            frame_err     <= 1'b0;
            unknown_err   <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            rx_byte_valid <= good_stop;
            if (good_stop)
                rx_data <= shift;
            if (new_cmd && (!cmd_valid || cmd_ready)) begin
                command   <= dec_code;
                cmd_valid <= 1'b1;
            end else if (!new_cmd && cmd_valid && cmd_ready)
                cmd_valid <= 1'b0;
            frame_err   <= bad_stop | (frame_err & ~err_clear);
            unknown_err <= (good_stop & dec_unk) | (unknown_err & ~err_clear);
            overrun_err <= (new_cmd & cmd_valid & ~cmd_ready) | (overrun_err & ~err_clear);
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed frames from the test plan, then random frames,
// checked every cycle against a frame-level event model.
module tb_uart_cmd_rx;
    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, cmd_ready = 1'b0, err_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_byte_valid, cmd_valid, frame_err, unknown_err, overrun_err;
    logic [2:0] command;

    always #5 clk = ~clk;

    uart_cmd_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clk(clk), .reset(rst), .rx(rx), .cmd_ready(cmd_ready), .err_clear(err_clear),
        .rx_data(rx_data), .rx_byte_valid(rx_byte_valid), .command(command),
        .cmd_valid(cmd_valid), .frame_err(frame_err), .unknown_err(unknown_err),
        .overrun_err(overrun_err)
    );

    // edges from the first edge after the start fall to the stop-sample edge (TICK_DIV=1)
    localparam int LAT = 2 + 1 + (8 + 16 * 8 + 16);

    int vectors = 0, miscompares = 0, pulses = 0, cyc = 0;
    bit rand_hs = 1'b0;

    int         ev_edge [1024];
    logic [7:0] ev_byte [1024];
    bit         ev_good [1024];
    int         ev_wr = 0, ev_rd = 0;

    logic [7:0] tbl [8] = '{8'h53, 8'h46, 8'h42, 8'h4C, 8'h52, 8'h43, 8'h54, 8'h58};

    logic [7:0] m_data = 8'd0;
    logic [2:0] m_cmd = 3'd0, m_code = 3'd0;
    logic       m_bv = 1'b0, m_valid = 1'b0, m_fe = 1'b0, m_ue = 1'b0, m_oe = 1'b0;
    bit         m_hit, m_fs, m_us, m_os;

    // Model: each frame is a timed event; apply decode, handshake and flag rules there.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_data = 8'd0; m_cmd = 3'd0; m_bv = 1'b0; m_valid = 1'b0;
            m_fe = 1'b0; m_ue = 1'b0; m_oe = 1'b0;
            ev_rd = ev_wr;
        end else begin
            m_bv = 1'b0; m_hit = 1'b0; m_fs = 1'b0; m_us = 1'b0; m_os = 1'b0;
            if (ev_rd < ev_wr && ev_edge[ev_rd] == cyc) begin
                if (ev_good[ev_rd]) begin
                    m_bv = 1'b1;
                    m_data = ev_byte[ev_rd];
                    for (int j = 0; j < 8; j++)
                        if (m_data == tbl[j]) begin
                            m_hit = 1'b1;
                            m_code = j[2:0];
                        end
                    if (!m_hit && m_data != 8'h0D && m_data != 8'h0A) m_us = 1'b1;
                end else
                    m_fs = 1'b1;
                ev_rd = ev_rd + 1;
            end
            if (m_hit && m_valid && !cmd_ready) m_os = 1'b1;
            else if (m_hit) begin m_cmd = m_code; m_valid = 1'b1; end
            else if (m_valid && cmd_ready) m_valid = 1'b0;
            m_fe = m_fs | (m_fe & !err_clear);
            m_ue = m_us | (m_ue & !err_clear);
            m_oe = m_os | (m_oe & !err_clear);
        end
    end

    task automatic check_cycle();
        vectors++;
        if (rx_data !== m_data || rx_byte_valid !== m_bv || command !== m_cmd ||
            cmd_valid !== m_valid || frame_err !== m_fe || unknown_err !== m_ue ||
            overrun_err !== m_oe) begin
            miscompares++;
            $display("FAIL cycle %0d: dut data=%h bv=%b cmd=%0d v=%b fe=%b ue=%b oe=%b | model data=%h bv=%b cmd=%0d v=%b fe=%b ue=%b oe=%b",
                     cyc, rx_data, rx_byte_valid, command, cmd_valid, frame_err, unknown_err, overrun_err,
                     m_data, m_bv, m_cmd, m_valid, m_fe, m_ue, m_oe);
        end
        if (rx_byte_valid) pulses++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) check_cycle();
        @(posedge clk);
        #1;
        if (rand_hs) begin
            cmd_ready = ($urandom_range(0, 3) == 0);
            err_clear = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        ev_edge[ev_wr] = cyc + LAT;
        ev_byte[ev_wr] = b;
        ev_good[ev_wr] = stop;
        ev_wr = ev_wr + 1;
        repeat (16) step();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) step();
        end
        rx = stop;
        repeat (16) step();
        rx = 1'b1;
    endtask

    task automatic pulse_ready();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1; step(); err_clear = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rx_data"}, rx_data, 0);
        chk({tag, " rx_byte_valid"}, rx_byte_valid, 0);
        chk({tag, " command"}, command, 0);
        chk({tag, " cmd_valid"}, cmd_valid, 0);
        chk({tag, " flags"}, {frame_err, unknown_err, overrun_err}, 0);
    endtask

    initial begin
        int p0, r;
        logic [7:0] bb, rb;
        bit st;

        rst = 1'b1;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(10);

        send(8'h46, 1'b1); idle(10);
        chk("F rx_data", rx_data, 8'h46);
        chk("F command", command, 1);
        chk("F cmd_valid held", cmd_valid, 1);
        chk("F pulse count", pulses, 1);
        pulse_ready();
        chk("F cmd_valid after ready", cmd_valid, 0);

        send(8'h4C, 1'b1); send(8'h52, 1'b1); idle(10);
        chk("LR command", command, 3);
        chk("LR cmd_valid", cmd_valid, 1);
        chk("LR overrun", overrun_err, 1);
        pulse_clear();
        chk("LR overrun cleared", overrun_err, 0);
        pulse_ready();
        chk("LR cmd_valid dropped", cmd_valid, 0);

        p0 = pulses;
        send(8'h41, 1'b1); idle(5);
        chk("A unknown", unknown_err, 1);
        send(8'h0D, 1'b1); idle(10);
        chk("A/CR pulses", pulses - p0, 2);
        chk("A/CR cmd_valid", cmd_valid, 0);
        chk("A/CR unknown", unknown_err, 1);
        pulse_clear();
        chk("unknown cleared", unknown_err, 0);

        p0 = pulses;
        send(8'h53, 1'b0); idle(20);
        chk("badS frame_err", frame_err, 1);
        chk("badS cmd_valid", cmd_valid, 0);
        chk("badS pulses", pulses - p0, 0);
        send(8'h54, 1'b1); idle(10);
        chk("T command", command, 6);
        chk("T cmd_valid", cmd_valid, 1);
        pulse_ready();
        pulse_clear();
        chk("frame cleared", frame_err, 0);

        p0 = pulses;
        rx = 1'b0; idle(5); rx = 1'b1; idle(30);
        chk("glitch flags", {frame_err, unknown_err, overrun_err}, 0);
        chk("glitch pulses", pulses - p0, 0);
        send(8'h58, 1'b1); idle(10);
        chk("X command", command, 7);
        chk("X cmd_valid", cmd_valid, 1);
        pulse_ready();

        bb = 8'h42;
        rx = 1'b0; idle(16);
        for (int i = 0; i < 4; i++) begin rx = bb[i]; idle(16); end
        rx = bb[4]; idle(8);
        rst = 1'b1; #1;
        chk_zero("midframe reset");
        idle(3);
        rst = 1'b0;
        idle(20);
        rx = 1'b1; idle(40);
        chk("post reset no frame", {frame_err, unknown_err, rx_byte_valid, cmd_valid}, 0);
        send(8'h43, 1'b1); idle(10);
        chk("C command", command, 5);
        chk("C cmd_valid", cmd_valid, 1);
        pulse_ready();

        rand_hs = 1'b1;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) rb = tbl[$urandom_range(0, 7)];
            else if (r == 6) rb = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            else rb = 8'($urandom);
            st = ($urandom_range(0, 11) != 0);
            send(rb, st);
            idle(st ? $urandom_range(0, 20) : 12 + $urandom_range(0, 20));
        end
        rand_hs = 1'b0;
        cmd_ready = 1'b0; err_clear = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Base-side serial receiver for the robot's drive-command link. It deserialises 8N1 UART frames from the robot's transmit line using 16x oversampling and decodes each ASCII command character into a 3-bit drive command. Decoded commands are presented on a valid/ready handshake to base motor logic. Framing, unknown-character and overrun conditions are reported on sticky error flags.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line bit rate
TICK_DIV, CLK_FREQ/(BAUD*16) rounded to nearest integer (min 1), clocks per oversample tick; derived, not overridden

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
cmd_ready  input  1  consumer accepts the pending command
err_clear  input  1  synchronous pulse; clears all sticky error flags
rx_data  output  8  last received byte (raw)
rx_byte_valid  output  1  one-cycle pulse when a frame with a good stop bit completes
command  output  3  decoded drive command, stable while cmd_valid=1
cmd_valid  output  1  decoded command pending
frame_err  output  1  sticky: stop bit sampled low
unknown_err  output  1  sticky: good frame but character not in command table
overrun_err  output  1  sticky: valid command arrived while cmd_valid=1 and cmd_ready=0

Behaviour:
- Reset (async, active-high): all outputs 0; FSM=IDLE; tick counter and bit counter 0; synchroniser flops preset to 1 (idle line).
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- Tick generator: counter 0..TICK_DIV-1; tick pulses when it wraps. It is free-running while FSM!=IDLE and is held at 0 in IDLE.
- FSM states:
  - IDLE: rx_s==0 -> START, oversample count os=0.
  - START: at os==7 tick (mid start bit), if rx_s==1 (glitch) -> IDLE with no error; otherwise -> DATA with os=0, bit=0.
  - DATA: sample rx_s at os==15 tick into shift register LSB-first. After bit 7 -> STOP.
  - STOP: at os==15 tick, if rx_s==1 the frame is good, else set frame_err, drop the byte, and go to IDLE. After a good stop bit the FSM returns to IDLE immediately, so it can re-arm for a start bit in the second half of the stop bit.
- Good frame: on the cycle after the stop sample, rx_data is loaded and rx_byte_valid pulses for one cycle.
- Same cycle, decode ASCII, case-sensitive uppercase:
  - 'S'(0x53)->0, 'F'(0x46)->1, 'B'(0x42)->2, 'L'(0x4C)->3, 'R'(0x52)->4, 'C'(0x43)->5, 'T'(0x54)->6, 'X'(0x58)->7.
  - CR (0x0D) and LF (0x0A) are ignored silently.
  - Any other byte sets unknown_err; command and cmd_valid are unchanged.
- Handshake: a decoded command loads command and sets cmd_valid if cmd_valid==0, or if cmd_valid==1 and cmd_ready==1 in the same cycle (back-to-back replace, no drop). cmd_valid clears when cmd_valid&&cmd_ready and no new command arrives that cycle. If a new command arrives while cmd_valid=1 and cmd_ready=0, the new command is dropped, the old command is held, and overrun_err is set.
- Latency: rx falling edge to rx_byte_valid = 2 (sync) + 1 (IDLE detect) + (8+16*8+16)*TICK_DIV cycles, +1 register; ±1 tick of start-edge alignment error.
- err_clear clears all three flags. If err_clear and a set event occur in the same cycle, set wins.
- Line held low (break): frame_err is set once per frame period, and the FSM re-enters START on each detected low.
- Reset asserted mid-frame aborts the frame with no flags set. The partial frame is discarded after reset deasserts, because the FSM waits for the line to idle high before accepting a new start.

Test Plan:
- CLK_FREQ=1_600_000, BAUD=100_000 (TICK_DIV=1). Send 0x46 ('F') with cmd_ready=0 -> rx_byte_valid one pulse, rx_data=0x46, command=1, cmd_valid=1 held; raise cmd_ready -> cmd_valid=0 next cycle.
- Send 'L' then 'R' back-to-back (one stop bit) with cmd_ready=0 -> command=3 held, overrun_err=1; pulse err_clear -> overrun_err=0; assert cmd_ready -> cmd_valid drops.
- Send 0x41 ('A'), then 0x0D -> rx_byte_valid pulses twice, unknown_err=1 after 'A' only, cmd_valid stays 0.
- Send 'S' with stop bit driven 0 -> frame_err=1, no rx_byte_valid, cmd_valid=0; then send a clean 'T' -> command=6, cmd_valid=1.
- Pull rx low for 5 clocks then release (glitch shorter than half bit) -> no flags, no pulses, FSM back in IDLE; a following 'X' decodes to command=7.
- Assert reset during data bit 4 of 'B' -> all outputs 0 immediately; after release, next 'C' decodes to command=5.
